// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
//
// Command sequencer that sits between a UART receiver/transmitter pair and
// a combinational ALU. A command is three bytes: operand A, operand B and
// an opcode. Once the opcode arrives the controller spends one EXEC cycle
// sampling the ALU result into tx_data. It then pulses tx_start and waits
// in WAIT_TX for the transmitter to finish before accepting the next
// command. Bytes that arrive while busy are dropped and flagged with
// overrun_tick.
//
// Optional feature (compile-time macro UART_ALU_CTRL_TIMEOUT_EN):
//   In GET_B and GET_OP, an inter-byte counter abandons a partial command
//   after TIMEOUT_CYCLES idle clocks and pulses timeout_tick. Without the
//   macro there is no counter and timeout_tick is tied low.
//
// Parameters:
//   DBIT           width of bytes, operands and results
//   TIMEOUT_CYCLES inter-byte timeout in clk cycles (timeout build only)
//   CNT_W          timeout counter width (TIMEOUT_CYCLES < 2**CNT_W)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   rx_done_tick  byte strobe from uart_rx, rx_data valid in the same cycle
//   rx_data       received byte
//   alu_result    combinational ALU result for op_a/op_b/opcode
//   tx_done_tick  end-of-stop-bit strobe from uart_tx
//   op_a, op_b    registered operands to the ALU
//   opcode        registered ALU operation code
//   tx_data       registered result byte to uart_tx
//   tx_start      one-cycle send request to uart_tx
//   busy          high in EXEC and WAIT_TX
//   overrun_tick  one-cycle pulse after a byte was dropped while busy
//   timeout_tick  one-cycle pulse when a partial command is abandoned

module uart_alu_ctrl #(
    parameter int DBIT           = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_data,
    input  logic [DBIT-1:0] alu_result,
    input  logic            tx_done_tick,
    output logic [DBIT-1:0] op_a,
    output logic [DBIT-1:0] op_b,
    output logic [DBIT-1:0] opcode,
    output logic [DBIT-1:0] tx_data,
    output logic            tx_start,
    output logic            busy,
    output logic            overrun_tick,
    output logic            timeout_tick
);

    // Reject a counter too narrow to reach the terminal count.
    if ((TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_cfg_err
        $error("uart_alu_ctrl: TIMEOUT_CYCLES must be less than 2**CNT_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        EXEC,
        WAIT_TX
    } state_t;

    state_t          state_q,    state_d;
    logic [DBIT-1:0] op_a_q,     op_a_d;
    logic [DBIT-1:0] op_b_q,     op_b_d;
    logic [DBIT-1:0] opcode_q,   opcode_d;
    logic [DBIT-1:0] tx_data_q,  tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q,     busy_d;
    logic            overrun_q,  overrun_d;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // The counter only runs while waiting for operand B or the opcode.
        // Every other path, including an accepted byte, leaves it at zero.
        cnt_d      = '0;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (rx_done_tick) begin
                    op_a_d  = rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (rx_done_tick) begin
                    op_b_d  = rx_data;
                    state_d = GET_OP;
                end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
                // An arriving byte has priority over the timeout.
                else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            GET_OP: begin
                if (rx_done_tick) begin
                    opcode_d = rx_data;
                    state_d  = EXEC;
                end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            EXEC: begin
                // The operands settled in the previous cycle, so the ALU
                // output is stable here and can be captured directly.
                tx_data_d  = alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
                overrun_d  = rx_done_tick;
            end
            WAIT_TX: begin
                // A byte coinciding with tx_done still counts as an overrun.
                overrun_d = rx_done_tick;
                if (tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == EXEC) || (state_d == WAIT_TX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign opcode       = opcode_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign busy         = busy_q;
    assign overrun_tick = overrun_q;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    assign timeout_tick = timeout_q;
`else
    assign timeout_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl. It acts as the ALU, where 0x20 is add,
// 0x21 is subtract and any other opcode is xor, and it drives the UART
// strobes. Every expected result and its tx_start cycle go into a
// scoreboard when the opcode byte is sent. A negedge monitor pops and
// compares them whenever tx_start is seen. Build with
// +define+UART_ALU_CTRL_TIMEOUT_EN to exercise the timeout variant.

module tb_uart_alu_ctrl;

    localparam int DBIT = 8;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 50000;
`endif

    logic            clk;
    logic            reset;
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_data;
    logic [DBIT-1:0] alu_result;
    logic            tx_done_tick;
    logic [DBIT-1:0] op_a, op_b, opcode, tx_data;
    logic            tx_start, busy, overrun_tick, timeout_tick;

    uart_alu_ctrl #(
        .DBIT           (DBIT),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .op_a         (op_a),
        .op_b         (op_b),
        .opcode       (opcode),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .busy         (busy),
        .overrun_tick (overrun_tick),
        .timeout_tick (timeout_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DBIT-1:0] alu_model(input logic [DBIT-1:0] a,
                                                  input logic [DBIT-1:0] b,
                                                  input logic [DBIT-1:0] op);
        case (op)
            8'h20:   return a + b;
            8'h21:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_model(op_a, op_b, opcode);

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DBIT-1:0] exp_q[$];
    int              exp_cyc_q[$];
    int              ncyc        = 0;
    int              starts_seen = 0;
    int              pushed      = 0;
    int              ovr_cnt     = 0;
    int              tmo_cnt     = 0;
    logic [DBIT-1:0] mon_d;
    int              mon_c;

    always @(negedge clk) begin
        ncyc++;
        if (overrun_tick) ovr_cnt++;
        if (timeout_tick) tmo_cnt++;
        if (tx_start) begin
            starts_seen++;
            if (exp_q.size() == 0) begin
                chk_eq("tx_start_unexpected", 32'h1, 32'h0);
            end else begin
                mon_d = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                chk_eq("tx_data", 32'(tx_data), 32'(mon_d));
                chk_eq("tx_start_cycle", 32'(ncyc), 32'(mon_c));
            end
        end
    end

    // All tasks below assume they are entered 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [DBIT-1:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    // tx_start must be seen in the third cycle counted from the opcode tick.
    task automatic expect_result(input logic [DBIT-1:0] v);
        exp_q.push_back(v);
        exp_cyc_q.push_back(ncyc + 3);
        pushed++;
    endtask

    task automatic send_cmd(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b,
                            input logic [DBIT-1:0] op, input bit expect_out);
        send_byte(a);
        send_byte(b);
        if (expect_out) expect_result(alu_model(a, b, op));
        send_byte(op);
    endtask

    task automatic wait_starts();
        for (int i = 0; i < 50 && starts_seen < pushed; i++) idle(1);
        chk_eq("tx_start_seen", 32'(starts_seen), 32'(pushed));
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_op_a"},     32'(op_a),         32'h0);
        chk_eq({tag, "_op_b"},     32'(op_b),         32'h0);
        chk_eq({tag, "_opcode"},   32'(opcode),       32'h0);
        chk_eq({tag, "_tx_data"},  32'(tx_data),      32'h0);
        chk_eq({tag, "_tx_start"}, 32'(tx_start),     32'h0);
        chk_eq({tag, "_busy"},     32'(busy),         32'h0);
        chk_eq({tag, "_overrun"},  32'(overrun_tick), 32'h0);
        chk_eq({tag, "_timeout"},  32'(timeout_tick), 32'h0);
    endtask

    initial begin
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = '0;
        tx_done_tick = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        chk_all_zero("reset");
        reset = 1'b1;
        idle(2);

        // Basic add command with latency and busy checks.
        send_cmd(8'h05, 8'h03, 8'h20, 1'b1);
        chk_eq("busy_exec", 32'(busy),   32'h1);
        chk_eq("op_a",      32'(op_a),   32'h05);
        chk_eq("op_b",      32'(op_b),   32'h03);
        chk_eq("opcode",    32'(opcode), 32'h20);
        wait_starts();
        chk_eq("tx_data_hold", 32'(tx_data), 32'h08);
        chk_eq("busy_wait_tx", 32'(busy),    32'h1);
        idle(3);
        pulse_tx_done();
        chk_eq("busy_idle", 32'(busy), 32'h0);

        // Stray tx_done in IDLE and GET_B, then a byte landing in EXEC.
        pulse_tx_done();
        send_byte(8'h10);
        pulse_tx_done();
        send_byte(8'h20);
        expect_result(8'h30);
        send_byte(8'h20);
        send_byte(8'h77);
        wait_starts();
        idle(1);
        chk_eq("overrun_exec", 32'(ovr_cnt), 32'd1);
        chk_eq("op_a_kept",    32'(op_a),    32'h10);

        // Byte arriving in WAIT_TX.
        send_byte(8'hAA);
        idle(2);
        chk_eq("overrun_wait_tx",   32'(ovr_cnt), 32'd2);
        chk_eq("tx_data_unchanged", 32'(tx_data), 32'h30);
        chk_eq("op_a_after_ovr",    32'(op_a),    32'h10);
        chk_eq("busy_still",        32'(busy),    32'h1);
        pulse_tx_done();
        chk_eq("busy_after_done", 32'(busy), 32'h0);

        // rx and tx_done in the same WAIT_TX cycle.
        send_cmd(8'h01, 8'h02, 8'h20, 1'b1);
        wait_starts();
        idle(2);
        rx_data      = 8'h55;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        idle(1);
        chk_eq("overrun_simul", 32'(ovr_cnt), 32'd3);
        chk_eq("busy_simul",    32'(busy),    32'h0);
        chk_eq("op_a_simul",    32'(op_a),    32'h01);

        // Back-to-back commands, second starting the cycle after tx_done.
        send_cmd(8'h0F, 8'h01, 8'h20, 1'b1);
        wait_starts();
        idle(2);
        pulse_tx_done();
        send_cmd(8'hFF, 8'h01, 8'h20, 1'b1);
        wait_starts();
        chk_eq("op_a_second", 32'(op_a), 32'hFF);
        pulse_tx_done();

        // Reset while waiting for the transmitter.
        send_cmd(8'h02, 8'h02, 8'h20, 1'b1);
        wait_starts();
        idle(1);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_wait_tx");
        idle(2);
        reset = 1'b1;
        idle(2);

        // Reset in the EXEC cycle: the command must never produce tx_start.
        send_cmd(8'h03, 8'h03, 8'h20, 1'b0);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_exec");
        idle(2);
        reset = 1'b1;
        idle(5);
        chk_eq("no_start_after_reset", 32'(starts_seen), 32'(pushed));

        // Normal operation after reset, including subtract with borrow.
        send_cmd(8'h04, 8'h05, 8'h20, 1'b1);
        wait_starts();
        idle(2);
        pulse_tx_done();
        send_cmd(8'h10, 8'h20, 8'h21, 1'b1);
        wait_starts();
        pulse_tx_done();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // Partial command abandoned after TMO idle cycles.
        send_byte(8'h05);
        idle(102);
        chk_eq("timeout_fired",     32'(tmo_cnt), 32'd1);
        chk_eq("timeout_busy",      32'(busy),    32'h0);
        chk_eq("op_a_retained",     32'(op_a),    32'h05);
        send_cmd(8'h07, 8'h01, 8'h20, 1'b1);
        wait_starts();
        pulse_tx_done();

        // Second byte lands on the terminal-count cycle and wins.
        send_byte(8'h05);
        idle(TMO - 1);
        send_byte(8'h03);
        expect_result(8'h08);
        send_byte(8'h20);
        wait_starts();
        pulse_tx_done();
        idle(TMO + 5);
        chk_eq("timeout_not_fired", 32'(tmo_cnt), 32'd1);
`else
        // Long gap inside a command is tolerated.
        send_byte(8'h05);
        idle(10000);
        send_byte(8'h03);
        expect_result(8'h08);
        send_byte(8'h20);
        wait_starts();
        pulse_tx_done();
        chk_eq("timeout_never", 32'(tmo_cnt), 32'd0);
`endif

        idle(5);
        chk_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
